bram_frame_fifo_ctrl: RTL and testbench

- Store-and-forward frame FIFO controller that sequences one external simple dual-port BRAM.
  - BRAM has 1-cycle registered read and read-before-write behaviour.
  - Write side: MAC/parser byte stream.
  - Read side: downstream consumer with valid/ready backpressure.
- Frames are released to the read side only after an error-free last beat has been written.
- Errored or overflowing frames are rewound and dropped whole.

---
 rtl/bram_frame_fifo_ctrl.sv | 130 +++++++++++++
 tb/tb_bram_frame_fifo_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_frame_fifo_ctrl.sv
// Store-and-forward frame FIFO controller driving an external simple dual-port BRAM.
// Frames become visible to the reader only once their error-free last beat is committed.
module bram_frame_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic              in_err_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              bram_wr_en_o,
  output logic [ADDR_W-1:0] bram_wr_addr_o,
  output logic [DATA_W:0]   bram_wr_data_o,
  output logic [ADDR_W-1:0] bram_rd_addr_o,
  input  logic [DATA_W:0]   bram_rd_data_i,
  output logic [ADDR_W:0]   level_o,
  output logic [15:0]       drop_cnt_o
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, FRAME, DROP} wstate_e;

  wstate_e          state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    commit_q, commit_d;
  logic [PW-1:0]    rd_ptr_q;
  logic [15:0]      drop_cnt_q;
  logic             drop_inc;
  logic             space;

  logic [1:0][DATA_W:0] buf_q;
  logic             head_q;
  logic [1:0]       occ_q;
  logic             inflight_q;
  logic             pop, issue, wr_idx;

  // Space is judged against issued reads so a slot is never overwritten before it is fetched.
  assign space = (wr_ptr_q - rd_ptr_q) < DEPTH;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_d     = commit_q;
    drop_inc     = 1'b0;
    bram_wr_en_o = 1'b0;
    case (state_q)
      IDLE, FRAME: begin
        if (in_valid_i) begin
          if (space) begin
            bram_wr_en_o = 1'b1;
            wr_ptr_d     = wr_ptr_q + PW'(1);
            if (!in_last_i) begin
              state_d = FRAME;
            end else if (!in_err_i) begin
              commit_d = wr_ptr_q + PW'(1);
              state_d  = IDLE;
            end else begin
              wr_ptr_d = commit_q;
              drop_inc = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            wr_ptr_d = commit_q;
            drop_inc = 1'b1;
            state_d  = in_last_i ? IDLE : DROP;
          end
        end
      end
      DROP: if (in_valid_i && in_last_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      commit_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bram_wr_addr_o = wr_ptr_q[ADDR_W-1:0];
  assign bram_wr_data_o = {in_last_i, in_data_i};

  // Read side: keep buffered + in-flight beats at most 2 so a returning read always has a slot.
  assign out_valid_o = (occ_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  assign issue       = (rd_ptr_q != commit_q) &&
                       (({1'b0, occ_q} + {2'b0, inflight_q}) <= (3'd1 + {2'b0, pop}));
  assign wr_idx      = head_q ^ occ_q[0];
  assign bram_rd_addr_o = rd_ptr_q[ADDR_W-1:0];
  assign out_data_o  = buf_q[head_q][DATA_W-1:0];
  assign out_last_o  = buf_q[head_q][DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      buf_q      <= '0;
      head_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (inflight_q) buf_q[wr_idx] <= bram_rd_data_i;
      if (pop) head_q <= ~head_q;
      case ({inflight_q, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign level_o    = commit_q - rd_ptr_q;
  assign drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_bram_frame_fifo_ctrl.sv
// Directed bench for bram_frame_fifo_ctrl with a behavioural read-before-write BRAM.
module tb_bram_frame_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid_i = 1'b0, in_last_i = 1'b0, in_err_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic          out_ready_i = 1'b0;
  logic          out_valid_o, out_last_o;
  logic [DW-1:0] out_data_o;
  logic          bram_wr_en_o;
  logic [AW-1:0] bram_wr_addr_o, bram_rd_addr_o;
  logic [DW:0]   bram_wr_data_o, bram_rd_data;
  logic [AW:0]   level_o;
  logic [15:0]   drop_cnt_o;

  logic [DW:0]   mem [0:(1<<AW)-1];
  int            cyc = 0;
  int            n_cmp = 0, n_err = 0;
  logic [DW-1:0] q_d[$];
  logic          q_l[$];
  int            q_c[$];
  logic          we;
  logic [AW-1:0] wa;
  int            c0;

  always #5 clk = ~clk;

  bram_frame_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_last_i(in_last_i), .in_err_i(in_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .bram_wr_en_o(bram_wr_en_o), .bram_wr_addr_o(bram_wr_addr_o),
    .bram_wr_data_o(bram_wr_data_o), .bram_rd_addr_o(bram_rd_addr_o),
    .bram_rd_data_i(bram_rd_data), .level_o(level_o), .drop_cnt_o(drop_cnt_o)
  );

  always @(posedge clk) begin
    if (bram_wr_en_o) mem[bram_wr_addr_o] <= bram_wr_data_o;
    bram_rd_data <= mem[bram_rd_addr_o];
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst && out_valid_o && out_ready_i) begin
      q_d.push_back(out_data_o);
      q_l.push_back(out_last_o);
      q_c.push_back(cyc);
    end
  end

  task automatic clear_q();
    q_d.delete(); q_l.delete(); q_c.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    in_valid_i = 0; in_last_i = 0; in_err_i = 0; in_data_i = '0;
    rst = 0;
    wait_cyc(2);
    rst = 1;
    wait_cyc(1);
    clear_q();
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l, input logic e,
                      output logic we_o, output logic [AW-1:0] wa_o);
    in_valid_i = 1; in_data_i = d; in_last_i = l; in_err_i = e;
    #1;
    we_o = bram_wr_en_o; wa_o = bram_wr_addr_o;
    @(posedge clk); #1;
    in_valid_i = 0; in_last_i = 0; in_err_i = 0; in_data_i = '0;
  endtask

  task automatic test_reset();
    rst = 0; #1;
    n_cmp++;
    if ({out_valid_o, out_data_o, out_last_o} !== '0) begin
      n_err++; $display("FAIL reset_out: got v=%b d=%h l=%b, want 0", out_valid_o, out_data_o, out_last_o);
    end
    n_cmp++;
    if ({bram_wr_en_o, level_o, drop_cnt_o} !== '0) begin
      n_err++; $display("FAIL reset_misc: got we=%b lvl=%0d drop=%0d, want 0", bram_wr_en_o, level_o, drop_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    out_ready_i = 1;
    for (int i = 1; i <= 5; i++) beat(DW'(i), i == 5, 1'b0, we, wa);
    c0 = cyc;
    n_cmp++;
    if (level_o !== 5'd5) begin n_err++; $display("FAIL basic_level_commit: got %0d want 5", level_o); end
    wait_cyc(12);
    n_cmp++;
    if (q_d.size() !== 5) begin n_err++; $display("FAIL basic_count: got %0d want 5", q_d.size()); end
    for (int i = 0; i < 5 && i < q_d.size(); i++) begin
      n_cmp++;
      if (q_d[i] !== DW'(i + 1) || q_l[i] !== (i == 4) || q_c[i] !== c0 + 2 + i) begin
        n_err++;
        $display("FAIL basic_beat%0d: got d=%h l=%b cyc=%0d want d=%h l=%b cyc=%0d",
                 i, q_d[i], q_l[i], q_c[i], i + 1, i == 4, c0 + 2 + i);
      end
    end
    n_cmp++;
    if (level_o !== 5'd0) begin n_err++; $display("FAIL basic_level_end: got %0d want 0", level_o); end
  endtask

  task automatic test_err_drop();
    do_reset();
    out_ready_i = 1;
    for (int i = 0; i < 4; i++) beat(8'h10 + DW'(i), i == 3, i == 3, we, wa);
    beat(8'hA0, 1'b0, 1'b0, we, wa);
    n_cmp++;
    if (we !== 1'b1 || wa !== 4'd0) begin
      n_err++; $display("FAIL err_rewind_addr: got we=%b addr=%0d want we=1 addr=0", we, wa);
    end
    beat(8'hA1, 1'b1, 1'b0, we, wa);
    wait_cyc(10);
    n_cmp++;
    if (q_d.size() !== 2) begin n_err++; $display("FAIL err_count: got %0d want 2", q_d.size()); end
    else begin
      n_cmp++;
      if (q_d[0] !== 8'hA0 || q_l[0] !== 1'b0 || q_d[1] !== 8'hA1 || q_l[1] !== 1'b1) begin
        n_err++; $display("FAIL err_data: got %h/%b %h/%b want a0/0 a1/1", q_d[0], q_l[0], q_d[1], q_l[1]);
      end
    end
    n_cmp++;
    if (drop_cnt_o !== 16'd1) begin n_err++; $display("FAIL err_dropcnt: got %0d want 1", drop_cnt_o); end
  endtask

  task automatic test_full();
    do_reset();
    out_ready_i = 0;
    for (int i = 0; i < 16; i++) beat(8'h80 + DW'(i), i == 15, 1'b0, we, wa);
    n_cmp++;
    if (level_o !== 5'd16) begin n_err++; $display("FAIL full_level: got %0d want 16", level_o); end
    for (int i = 0; i < 3; i++) begin
      beat(8'hC0 + DW'(i), i == 2, 1'b0, we, wa);
      n_cmp++;
      if (we !== 1'b0) begin n_err++; $display("FAIL full_nowrite%0d: got we=%b want 0", i, we); end
    end
    n_cmp++;
    if (drop_cnt_o !== 16'd1) begin n_err++; $display("FAIL full_dropcnt: got %0d want 1", drop_cnt_o); end
    out_ready_i = 1;
    wait_cyc(30);
    n_cmp++;
    if (q_d.size() !== 16) begin n_err++; $display("FAIL full_count: got %0d want 16", q_d.size()); end
    for (int i = 0; i < 16 && i < q_d.size(); i++) begin
      n_cmp++;
      if (q_d[i] !== 8'h80 + DW'(i) || q_l[i] !== (i == 15)) begin
        n_err++; $display("FAIL full_beat%0d: got d=%h l=%b want d=%h l=%b", i, q_d[i], q_l[i], 8'h80 + i, i == 15);
      end
    end
    n_cmp++;
    if (level_o !== 5'd0) begin n_err++; $display("FAIL full_level_end: got %0d want 0", level_o); end
  endtask

  task automatic test_toggle();
    logic          stall;
    logic [DW-1:0] sd;
    logic          sl;
    do_reset();
    out_ready_i = 0;
    for (int i = 0; i < 6; i++) beat(8'h61 + DW'(i), i == 5, 1'b0, we, wa);
    wait_cyc(4);
    stall = 0; sd = '0; sl = 0;
    for (int i = 0; i < 30; i++) begin
      out_ready_i = (i % 2 == 0);
      @(negedge clk);
      if (stall) begin
        n_cmp++;
        if (out_valid_o !== 1'b1 || out_data_o !== sd || out_last_o !== sl) begin
          n_err++; $display("FAIL toggle_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                            out_valid_o, out_data_o, out_last_o, sd, sl);
        end
      end
      stall = out_valid_o && !out_ready_i;
      sd = out_data_o; sl = out_last_o;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (q_d.size() !== 6) begin n_err++; $display("FAIL toggle_count: got %0d want 6", q_d.size()); end
    for (int i = 0; i < 6 && i < q_d.size(); i++) begin
      n_cmp++;
      if (q_d[i] !== 8'h61 + DW'(i) || q_l[i] !== (i == 5)) begin
        n_err++; $display("FAIL toggle_beat%0d: got d=%h l=%b want d=%h l=%b", i, q_d[i], q_l[i], 8'h61 + i, i == 5);
      end
    end
    out_ready_i = 1;
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready_i = 0;
    beat(8'h31, 1'b0, 1'b0, we, wa);
    beat(8'h32, 1'b1, 1'b0, we, wa);
    wait_cyc(3);
    for (int i = 0; i < 3; i++) beat(8'h41 + DW'(i), 1'b0, 1'b0, we, wa);
    rst = 0; #1;
    n_cmp++;
    if ({out_valid_o, out_data_o, out_last_o, bram_wr_en_o} !== '0 || level_o !== '0 || drop_cnt_o !== '0) begin
      n_err++; $display("FAIL midrst_outputs: got v=%b d=%h l=%b we=%b lvl=%0d drop=%0d want all 0",
                        out_valid_o, out_data_o, out_last_o, bram_wr_en_o, level_o, drop_cnt_o);
    end
    @(posedge clk); #1;
    rst = 1;
    clear_q();
    wait_cyc(2);
    out_ready_i = 1;
    beat(8'h55, 1'b0, 1'b0, we, wa);
    beat(8'h56, 1'b1, 1'b0, we, wa);
    wait_cyc(10);
    n_cmp++;
    if (q_d.size() !== 2) begin n_err++; $display("FAIL midrst_count: got %0d want 2", q_d.size()); end
    else begin
      n_cmp++;
      if (q_d[0] !== 8'h55 || q_l[0] !== 1'b0 || q_d[1] !== 8'h56 || q_l[1] !== 1'b1) begin
        n_err++; $display("FAIL midrst_data: got %h/%b %h/%b want 55/0 56/1", q_d[0], q_l[0], q_d[1], q_l[1]);
      end
    end
    n_cmp++;
    if (drop_cnt_o !== 16'd0) begin n_err++; $display("FAIL midrst_dropcnt: got %0d want 0", drop_cnt_o); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    do_reset();
    out_ready_i = 1;
    beat(exp_d[0], 1'b1, 1'b0, we, wa);
    c0 = cyc;
    beat(exp_d[1], 1'b1, 1'b0, we, wa);
    beat(exp_d[2], 1'b1, 1'b0, we, wa);
    wait_cyc(10);
    n_cmp++;
    if (q_d.size() !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", q_d.size()); end
    for (int i = 0; i < 3 && i < q_d.size(); i++) begin
      n_cmp++;
      if (q_d[i] !== exp_d[i] || q_l[i] !== 1'b1 || q_c[i] !== c0 + 2 + i) begin
        n_err++; $display("FAIL b2b_beat%0d: got d=%h l=%b cyc=%0d want d=%h l=1 cyc=%0d",
                          i, q_d[i], q_l[i], q_c[i], exp_d[i], c0 + 2 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err_drop();
    test_full();
    test_toggle();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
